// File: rtl/ula_pkg.sv
// Shared opcodes, flag bit positions and FSM state encoding for the stack ULA.
package ula_pkg;

  localparam logic [4:0] ULA_ADD = 5'd0;
  localparam logic [4:0] ULA_SUB = 5'd1;
  localparam logic [4:0] ULA_MUL = 5'd2;
  localparam logic [4:0] ULA_SHL = 5'd3;
  localparam logic [4:0] ULA_SHR = 5'd4;
  localparam logic [4:0] ULA_OR  = 5'd5;
  localparam logic [4:0] ULA_AND = 5'd6;
  localparam logic [4:0] ULA_XOR = 5'd7;
  localparam logic [4:0] ULA_NOT = 5'd8;
  localparam logic [4:0] ULA_EQ  = 5'd9;
  localparam logic [4:0] ULA_NE  = 5'd10;
  localparam logic [4:0] ULA_GT  = 5'd11;
  localparam logic [4:0] ULA_LT  = 5'd12;
  localparam logic [4:0] ULA_GE  = 5'd13;
  localparam logic [4:0] ULA_LE  = 5'd14;
  localparam logic [4:0] ULA_DIV = 5'd15;
  localparam logic [4:0] ULA_MOD = 5'd16;
  localparam logic [4:0] ULA_ASR = 5'd17;

  localparam int FLAG_ZERO = 0;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_OVF  = 2;
  localparam int FLAG_ERR  = 3;

  typedef enum logic [1:0] {IDLE, ITER, FINISH} ula_state_e;

endpackage

// File: rtl/ula_iter_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// The divider half exists only when ULA_ITER_DIV_EN is defined.
module ula_iter_muldiv
  import ula_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      mode,     // 0 multiply, 1 divide
  input  logic [DATA_WIDTH-1:0]     op_a,     // multiplicand / dividend
  input  logic [DATA_WIDTH-1:0]     op_b,     // multiplier / divisor
  output logic                      busy,
  output logic                      done,
  output logic [2*DATA_WIDTH-1:0]   result    // {hi, lo} or {remainder, quotient}
);

  localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1;
  localparam int W = DATA_WIDTH;

  ula_state_e         state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]     acc_q, acc_d;
  logic [W-1:0]       opnd_q, opnd_d;
  logic [2*W-1:0]     step;
  logic [W:0]         mul_sum;
  logic [2*W-1:0]     mul_next;

  // acc = {partial product, remaining multiplier bits}; add then shift right.
  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[W-1:1]};

`ifdef ULA_ITER_DIV_EN
  logic         mode_q, mode_d;
  logic [W:0]   div_shift;
  logic [W:0]   div_trial;
  logic [W-1:0] div_rem;

  // acc = {remainder, dividend/quotient}; a zero divisor naturally yields
  // an all-ones quotient and a remainder equal to the dividend.
  assign div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
  assign div_trial = div_shift - {1'b0, opnd_q};
  assign div_rem   = div_trial[W] ? div_shift[W-1:0] : div_trial[W-1:0];
  assign step      = mode_q ? {div_rem, acc_q[W-2:0], ~div_trial[W]} : mul_next;

  assign mode_d = (state_q == IDLE && start) ? mode : mode_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mode_q <= 1'b0;
    else     mode_q <= mode_d;
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign step        = mul_next;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = mode ? {{W{1'b0}}, op_a} : {{W{1'b0}}, op_b};
          opnd_d  = mode ? op_b : op_a;
          cnt_d   = CNT_WIDTH'(DATA_WIDTH);
          state_d = ITER;
        end
      end
      ITER: begin
        acc_d = step;
        cnt_d = cnt_q - CNT_WIDTH'(1);
        if (cnt_q == CNT_WIDTH'(1)) state_d = FINISH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == FINISH);
  assign result = acc_q;

endmodule

// File: rtl/stack_ula_seq.sv
// Stack-processor ULA: operand registers, single-cycle ops, flags and a
// START/BUSY/DONE handshake. Define ULA_ITER_DIV_EN to enable DIV/MOD.
module stack_ula_seq
  import ula_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] REG_IN,
  input  logic                  CTRL_REG_OP1,
  input  logic                  CTRL_REG_OP2,
  input  logic                  START,
  input  logic [4:0]            SEL_ULA,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [DATA_WIDTH-1:0] ULA_OUT,
  output logic                  COMP_OUT,
  output logic [3:0]            FLAGS
);

  localparam int W = DATA_WIDTH;

  logic [W-1:0] op1_q, op1_d, op2_q, op2_d;
  logic [4:0]   sel_q, sel_d;
  logic [W-1:0] out_q, out_d;
  logic         comp_q, comp_d;
  logic [3:0]   flags_q, flags_d;
  logic         done_q, done_d;

  logic           it_busy, it_done, it_start, accept;
  logic [2*W-1:0] it_res;
  logic [W-1:0]   sc_out, it_out, res_out;
  logic           sc_comp, sc_ovf, sc_err, it_ovf, it_err, res_ovf, res_err;
  logic [2*W-1:0] shl_wide;
  logic           op1_big;

  function automatic logic is_iter(input logic [4:0] sel);
`ifdef ULA_ITER_DIV_EN
    return (sel == ULA_MUL) || (sel == ULA_DIV) || (sel == ULA_MOD);
`else
    return (sel == ULA_MUL);
`endif
  endfunction

  assign accept   = START && !it_busy;
  assign it_start = accept && is_iter(SEL_ULA);

  ula_iter_muldiv #(.DATA_WIDTH(DATA_WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (it_start),
    .mode   (SEL_ULA != ULA_MUL),
    .op_a   (op2_q),
    .op_b   (op1_q),
    .busy   (it_busy),
    .done   (it_done),
    .result (it_res)
  );

  assign shl_wide = {{W{1'b0}}, op2_q} << op1_q;
  assign op1_big  = (op1_q >= W'(DATA_WIDTH));

  always_comb begin
    sc_out  = '0;
    sc_comp = 1'b0;
    sc_ovf  = 1'b0;
    sc_err  = 1'b0;
    case (SEL_ULA)
      ULA_ADD: {sc_ovf, sc_out} = {1'b0, op2_q} + {1'b0, op1_q};
      ULA_SUB: begin
        sc_out = op2_q - op1_q;
        sc_ovf = (op2_q < op1_q);
      end
      ULA_SHL: begin
        sc_out = shl_wide[W-1:0];
        sc_ovf = op1_big ? (|op2_q) : (|shl_wide[2*W-1:W]);
      end
      ULA_SHR: sc_out = op2_q >> op1_q;
      ULA_ASR: sc_out = op1_big ? {W{op2_q[W-1]}} : W'($signed(op2_q) >>> op1_q);
      ULA_OR:  sc_out = op2_q | op1_q;
      ULA_AND: sc_out = op2_q & op1_q;
      ULA_XOR: sc_out = op2_q ^ op1_q;
      ULA_NOT: sc_out = ~op1_q;
      ULA_EQ:  sc_comp = (op2_q == op1_q);
      ULA_NE:  sc_comp = (op2_q != op1_q);
      ULA_GT:  sc_comp = (op2_q >  op1_q);
      ULA_LT:  sc_comp = (op2_q <  op1_q);
      ULA_GE:  sc_comp = (op2_q >= op1_q);
      ULA_LE:  sc_comp = (op2_q <= op1_q);
      default: sc_err = 1'b1;
    endcase
  end

`ifdef ULA_ITER_DIV_EN
  logic div0_q, div0_d;
  assign div0_d = it_start ? (op1_q == '0) : div0_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) div0_q <= 1'b0;
    else     div0_q <= div0_d;
  end
`endif

  always_comb begin
    it_out = it_res[W-1:0];
    it_ovf = 1'b0;
    it_err = 1'b0;
    case (sel_q)
      ULA_MUL: it_ovf = |it_res[2*W-1:W];
`ifdef ULA_ITER_DIV_EN
      ULA_DIV: it_err = div0_q;
      ULA_MOD: begin
        it_out = it_res[2*W-1:W];
        it_err = div0_q;
      end
`endif
      default: it_err = 1'b1;
    endcase
  end

  always_comb begin
    op1_d   = CTRL_REG_OP1 ? REG_IN : op1_q;
    op2_d   = CTRL_REG_OP2 ? REG_IN : op2_q;
    sel_d   = it_start ? SEL_ULA : sel_q;
    out_d   = out_q;
    comp_d  = comp_q;
    flags_d = flags_q;
    done_d  = 1'b0;
    res_out = it_done ? it_out : sc_out;
    res_ovf = it_done ? it_ovf : sc_ovf;
    res_err = it_done ? it_err : sc_err;
    if (it_done || (accept && !is_iter(SEL_ULA))) begin
      out_d              = res_out;
      comp_d             = it_done ? 1'b0 : sc_comp;
      flags_d[FLAG_ZERO] = (res_out == '0);
      flags_d[FLAG_NEG]  = res_out[W-1];
      flags_d[FLAG_OVF]  = res_ovf;
      flags_d[FLAG_ERR]  = res_err;
      done_d             = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op1_q   <= '0;
      op2_q   <= '0;
      sel_q   <= '0;
      out_q   <= '0;
      comp_q  <= 1'b0;
      flags_q <= '0;
      done_q  <= 1'b0;
    end else begin
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
      comp_q  <= comp_d;
      flags_q <= flags_d;
      done_q  <= done_d;
    end
  end

  assign BUSY     = it_busy;
  assign DONE     = done_q;
  assign ULA_OUT  = out_q;
  assign COMP_OUT = comp_q;
  assign FLAGS    = flags_q;

endmodule

// File: tb/tb_stack_ula_seq.sv
// Scoreboard bench for stack_ula_seq at DATA_WIDTH=8; honours ULA_ITER_DIV_EN.
module tb_stack_ula_seq;
  import ula_pkg::*;

  localparam int W  = 8;
  localparam int LI = W + 2;   // iterative DONE latency
  localparam int BI = W + 1;   // iterative BUSY cycles

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] REG_IN = '0;
  logic         CTRL_REG_OP1 = 1'b0;
  logic         CTRL_REG_OP2 = 1'b0;
  logic         START = 1'b0;
  logic [4:0]   SEL_ULA = '0;
  logic         BUSY, DONE, COMP_OUT;
  logic [W-1:0] ULA_OUT;
  logic [3:0]   FLAGS;

  stack_ula_seq #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .REG_IN(REG_IN), .CTRL_REG_OP1(CTRL_REG_OP1),
    .CTRL_REG_OP2(CTRL_REG_OP2), .START(START), .SEL_ULA(SEL_ULA),
    .BUSY(BUSY), .DONE(DONE), .ULA_OUT(ULA_OUT), .COMP_OUT(COMP_OUT), .FLAGS(FLAGS)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string        name;
    logic [W-1:0] out;
    logic         comp;
    logic [3:0]   flags;
    int           cyc;
    int           busy;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   busy_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per DONE pulse.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cnt = 0;
      end else begin
        if (BUSY) busy_cnt++;
        if (DONE) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done: DONE at cycle %0d, expected none", cyc);
          end else begin
            e = sb.pop_front();
            $display("txn %s: out=0x%02h comp=%0d flags=%04b cyc=%0d busy=%0d",
                     e.name, ULA_OUT, COMP_OUT, FLAGS, cyc, busy_cnt);
            chk({e.name, ".out"},   32'(ULA_OUT),  32'(e.out));
            chk({e.name, ".comp"},  32'(COMP_OUT), 32'(e.comp));
            chk({e.name, ".flags"}, 32'(FLAGS),    32'(e.flags));
            chk({e.name, ".cycle"}, 32'(cyc),      32'(e.cyc));
            chk({e.name, ".busy"},  32'(busy_cnt), 32'(e.busy));
          end
          busy_cnt = 0;
        end
      end
    end
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic ld(input bit to_op2, input logic [W-1:0] v);
    REG_IN = v;
    if (to_op2) CTRL_REG_OP2 = 1'b1;
    else        CTRL_REG_OP1 = 1'b1;
    @(posedge clk); #1;
    CTRL_REG_OP1 = 1'b0;
    CTRL_REG_OP2 = 1'b0;
  endtask

  task automatic start_op(input logic [4:0] sel, input bit push, input string name,
                          input logic [W-1:0] out, input logic comp, input logic [3:0] flags,
                          input int lat, input int busy);
    SEL_ULA = sel;
    START   = 1'b1;
    if (push) sb.push_back(exp_t'{name, out, comp, flags, cyc + lat, busy});
    @(posedge clk); #1;
    START = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic op(input logic [4:0] sel, input string name, input logic [W-1:0] out,
                    input logic comp, input logic [3:0] flags, input int lat, input int busy);
    start_op(sel, 1'b1, name, out, comp, flags, lat, busy);
    drain();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset.out",   32'(ULA_OUT),  0);
    chk("reset.comp",  32'(COMP_OUT), 0);
    chk("reset.flags", 32'(FLAGS),    0);
    chk("reset.busy",  32'(BUSY),     0);
    chk("reset.done",  32'(DONE),     0);
    rst = 1'b0;
    @(posedge clk); #1;

    // ADD with carry out
    ld(1, 8'd200); ld(0, 8'd100);
    op(ULA_ADD, "add_carry", 8'd44, 0, 4'b0100, 1, 0);

    // MUL with high half nonzero; OP1 reloaded mid-operation
    ld(1, 8'd20); ld(0, 8'd13);
    start_op(ULA_MUL, 1, "mul_ovf", 8'd4, 0, 4'b0100, LI, BI);
    ld(0, 8'd99);
    drain();

    // Divider
    ld(1, 8'd100); ld(0, 8'd7);
`ifdef ULA_ITER_DIV_EN
    op(ULA_DIV, "div", 8'd14, 0, 4'b0000, LI, BI);
    op(ULA_MOD, "mod", 8'd2,  0, 4'b0000, LI, BI);
    ld(0, 8'd0);
    op(ULA_DIV, "div_zero", 8'hFF, 0, 4'b1010, LI, BI);
    ld(0, 8'd0);
    op(ULA_MOD, "mod_zero", 8'd100, 0, 4'b1000, LI, BI);
`else
    op(ULA_DIV, "div_off", 8'd0, 0, 4'b1001, 1, 0);
    op(ULA_MOD, "mod_off", 8'd0, 0, 4'b1001, 1, 0);
`endif

    // Compares on equal operands
    ld(1, 8'd5); ld(0, 8'd5);
    op(ULA_EQ,  "eq",  8'd0, 1, 4'b0001, 1, 0);
    op(ULA_GT,  "gt",  8'd0, 0, 4'b0001, 1, 0);
    op(ULA_LE,  "le",  8'd0, 1, 4'b0001, 1, 0);
    op(ULA_NE,  "ne",  8'd0, 0, 4'b0001, 1, 0);
    op(ULA_SUB, "sub_zero", 8'd0, 0, 4'b0001, 1, 0);
    op(5'd25,   "illegal25", 8'd0, 0, 4'b1001, 1, 0);
    ld(1, 8'd3);
    op(ULA_SUB, "sub_borrow", 8'hFE, 0, 4'b0110, 1, 0);

    // Logic ops and unsigned compares
    ld(1, 8'hF0); ld(0, 8'h0F);
    op(ULA_NOT, "not", 8'hF0, 0, 4'b0010, 1, 0);
    op(ULA_AND, "and", 8'h00, 0, 4'b0001, 1, 0);
    op(ULA_OR,  "or",  8'hFF, 0, 4'b0010, 1, 0);
    op(ULA_XOR, "xor", 8'hFF, 0, 4'b0010, 1, 0);
    op(ULA_GE,  "ge",  8'd0, 1, 4'b0001, 1, 0);
    op(ULA_LT,  "lt",  8'd0, 0, 4'b0001, 1, 0);

    ld(1, 8'd15); ld(0, 8'd17);
    op(ULA_MUL, "mul_255", 8'hFF, 0, 4'b0010, LI, BI);

    // Shifts, including amounts at and beyond the width
    ld(1, 8'h81); ld(0, 8'd1);
    op(ULA_SHL, "shl_out", 8'h02, 0, 4'b0100, 1, 0);
    ld(1, 8'h80); ld(0, 8'd9);
    op(ULA_ASR, "asr_fill", 8'hFF, 0, 4'b0010, 1, 0);
    ld(0, 8'd8);
    op(ULA_SHR, "shr_8", 8'h00, 0, 4'b0001, 1, 0);
    op(ULA_ASR, "asr_neg2", 8'hFF, 0, 4'b0010, 1, 0);
    ld(1, 8'h01);
    op(ULA_SHL, "shl_8", 8'h00, 0, 4'b0101, 1, 0);
    op(ULA_ASR, "asr_pos", 8'h00, 0, 4'b0001, 1, 0);

    // START accepted in the DONE cycle
    ld(1, 8'd20); ld(0, 8'd13);
    start_op(ULA_MUL, 1, "mul_b2b", 8'd4, 0, 4'b0100, LI, BI);
    for (int i = 0; i < 20 && !DONE; i++) begin
      @(posedge clk); #1;
    end
    op(ULA_ADD, "add_b2b", 8'd33, 0, 4'b0000, 1, 0);

    // START while BUSY is ignored
    start_op(ULA_MUL, 1, "mul_ign", 8'd4, 0, 4'b0100, LI, BI);
    repeat (3) begin
      @(posedge clk); #1;
    end
    start_op(ULA_ADD, 0, "", 8'd0, 0, 4'b0000, 0, 0);
    drain();

    // Reset during MUL cycle 4 aborts it
    start_op(ULA_MUL, 0, "", 8'd0, 0, 4'b0000, 0, 0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk("abort.busy",  32'(BUSY),     0);
    chk("abort.done",  32'(DONE),     0);
    chk("abort.out",   32'(ULA_OUT),  0);
    chk("abort.comp",  32'(COMP_OUT), 0);
    chk("abort.flags", 32'(FLAGS),    0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
    end
    op(ULA_ADD, "add_after_rst", 8'd0, 0, 4'b0001, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
